// File: rtl/ram_cycle_ctl_if.sv
// Bundle of CPU port, data-break port and static-RAM pins around ram_cycle_ctl.
// slave: the sequencer; master: the requesters plus the RAM model.
interface ram_cycle_ctl_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic              dma_inc;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ovf;

    logic [ADDR_W-1:0] ram_a;
    logic [DATA_W-1:0] ram_di;
    logic [DATA_W-1:0] ram_do;
    logic              ram_ce_n;
    logic              ram_we_n;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_inc, dma_addr, dma_wdata,
        input  ram_do,
        output cpu_ack, cpu_rdata, dma_ack, dma_rdata, dma_ovf,
        output ram_a, ram_di, ram_ce_n, ram_we_n, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_inc, dma_addr, dma_wdata,
        output ram_do,
        input  cpu_ack, cpu_rdata, dma_ack, dma_rdata, dma_ovf,
        input  ram_a, ram_di, ram_ce_n, ram_we_n, busy
    );
endinterface

// File: rtl/ram_cycle_ctl.sv
// Static-RAM cycle sequencer shared by CPU and data-break channel, with
// address/data setup and hold around the write strobe and an increment cycle.
module ram_cycle_ctl #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 12,
    parameter int STROBE_CYC = 1
) (
    input  logic          clk,
    input  logic          reset,
    ram_cycle_ctl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, RD, WR, HOLD, DONE} state_t;

    localparam int CNT_W = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  strobe_cnt_reg;
    logic              grant_dma_reg, last_dma_reg;
    logic              lat_write_reg, lat_inc_reg;
    logic [ADDR_W-1:0] ram_a_reg;
    logic [DATA_W-1:0] ram_di_reg, cpu_rdata_reg, dma_rdata_reg;
    logic              dma_ovf_reg, cpu_ack_reg, dma_ack_reg;
    logic              ce_n_reg, we_n_reg;

    logic              pick_dma, any_req, strobe_last;
    logic [DATA_W-1:0] inc_val;

    // DMA normally wins, but yields once to a waiting CPU after its own grant.
    assign pick_dma    = bus.dma_req && !(last_dma_reg && bus.cpu_req);
    assign any_req     = bus.dma_req || bus.cpu_req;
    assign strobe_last = (strobe_cnt_reg == CNT_W'(STROBE_CYC - 1));
    assign inc_val     = bus.ram_do + DATA_W'(1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = SETUP;
            SETUP:   state_next = lat_write_reg ? WR : RD;
            RD:      state_next = lat_inc_reg ? WR : DONE;
            WR:      if (strobe_last) state_next = HOLD;
            HOLD:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            strobe_cnt_reg <= '0;
            grant_dma_reg  <= 1'b0;
            last_dma_reg   <= 1'b0;
            lat_write_reg  <= 1'b0;
            lat_inc_reg    <= 1'b0;
            ram_a_reg      <= '0;
            ram_di_reg     <= '0;
            cpu_rdata_reg  <= '0;
            dma_rdata_reg  <= '0;
            dma_ovf_reg    <= 1'b0;
            cpu_ack_reg    <= 1'b0;
            dma_ack_reg    <= 1'b0;
            ce_n_reg       <= 1'b1;
            we_n_reg       <= 1'b1;
        end else begin
            state_reg <= state_next;
            // Strobes and acks are decoded from the next state so the pins come
            // straight from flops and never glitch.
            ce_n_reg    <= (state_next == IDLE) || (state_next == DONE);
            we_n_reg    <= (state_next != WR);
            cpu_ack_reg <= (state_next == DONE) && !grant_dma_reg;
            dma_ack_reg <= (state_next == DONE) && grant_dma_reg;

            if (state_reg == WR) strobe_cnt_reg <= strobe_cnt_reg + CNT_W'(1);
            else                 strobe_cnt_reg <= '0;

            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_dma_reg <= pick_dma;
                        last_dma_reg  <= pick_dma;
                        if (pick_dma) begin
                            ram_a_reg     <= bus.dma_addr;
                            ram_di_reg    <= bus.dma_wdata;
                            lat_write_reg <= bus.dma_we && !bus.dma_inc;
                            lat_inc_reg   <= bus.dma_inc;
                        end else begin
                            ram_a_reg     <= bus.cpu_addr;
                            ram_di_reg    <= bus.cpu_wdata;
                            lat_write_reg <= bus.cpu_we;
                            lat_inc_reg   <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (lat_inc_reg) begin
                        ram_di_reg    <= inc_val;
                        dma_rdata_reg <= inc_val;
                        dma_ovf_reg   <= &bus.ram_do;
                    end else if (grant_dma_reg) begin
                        dma_rdata_reg <= bus.ram_do;
                        dma_ovf_reg   <= 1'b0;
                    end else begin
                        cpu_rdata_reg <= bus.ram_do;
                    end
                end
                HOLD: begin
                    if (grant_dma_reg && !lat_inc_reg) dma_ovf_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_a     = ram_a_reg;
    assign bus.ram_di    = ram_di_reg;
    assign bus.ram_ce_n  = ce_n_reg;
    assign bus.ram_we_n  = we_n_reg;
    assign bus.cpu_ack   = cpu_ack_reg;
    assign bus.dma_ack   = dma_ack_reg;
    assign bus.cpu_rdata = cpu_rdata_reg;
    assign bus.dma_rdata = dma_rdata_reg;
    assign bus.dma_ovf   = dma_ovf_reg;
    assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_ram_cycle_ctl.sv
// Scoreboarded bench for ram_cycle_ctl: a STROBE_CYC=1 unit carries most
// scenarios, a STROBE_CYC=3 unit checks the stretched write strobe.
module tb_ram_cycle_ctl;
    localparam int S1 = 1;
    localparam int S3 = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_cycle_ctl_if #(.ADDR_W(15), .DATA_W(12)) bus1 ();
    ram_cycle_ctl_if #(.ADDR_W(15), .DATA_W(12)) bus3 ();

    ram_cycle_ctl #(.ADDR_W(15), .DATA_W(12), .STROBE_CYC(S1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));
    ram_cycle_ctl #(.ADDR_W(15), .DATA_W(12), .STROBE_CYC(S3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3.slave));

    // RAM models: combinational read, write while CE and WE are low; cleared on reset
    logic [11:0] mem1 [256];
    logic [11:0] mem3 [256];
    assign bus1.ram_do = mem1[bus1.ram_a[7:0]];
    assign bus3.ram_do = mem3[bus3.ram_a[7:0]];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= '0;
                mem3[i] <= '0;
            end
        end else begin
            if (!bus1.ram_ce_n && !bus1.ram_we_n) mem1[bus1.ram_a[7:0]] <= bus1.ram_di;
            if (!bus3.ram_ce_n && !bus3.ram_we_n) mem3[bus3.ram_a[7:0]] <= bus3.ram_di;
        end
    end

    // Address/data must not move between consecutive strobe-low samples and the following HOLD
    int          glitch_errs = 0;
    logic        prev_low = 1'b0;
    logic [14:0] prev_a;
    logic [11:0] prev_di;
    always @(negedge clk) begin
        if (prev_low && !bus1.ram_ce_n &&
            (bus1.ram_a !== prev_a || bus1.ram_di !== prev_di))
            glitch_errs++;
        prev_low = !bus1.ram_we_n;
        prev_a   = bus1.ram_a;
        prev_di  = bus1.ram_di;
    end

    typedef struct {
        bit          dma;
        int          lat;
        logic [11:0] rdata;
        logic        ovf;
        int          we_low;
    } exp_t;

    typedef struct {
        bit          dma;
        bit          we;
        bit          inc;
        logic [14:0] addr;
        logic [11:0] wdata;
    } txn_t;

    exp_t        sb [$];
    logic [11:0] ref_mem [256];
    logic [11:0] exp_cpu_rd, exp_dma_rd;
    logic        exp_ovf;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        exp_cpu_rd = '0;
        exp_dma_rd = '0;
        exp_ovf    = 1'b0;
    endtask

    // Reference model for one transaction on the STROBE_CYC=1 unit
    task automatic push_exp(input txn_t t);
        exp_t        e;
        logic [11:0] v;
        v = ref_mem[t.addr[7:0]];
        e.dma = t.dma;
        if (t.dma && t.inc) begin
            exp_ovf    = (v == 12'o7777);
            exp_dma_rd = v + 12'd1;
            ref_mem[t.addr[7:0]] = exp_dma_rd;
            e.lat = 4 + S1;
            e.we_low = S1;
        end else if (t.we) begin
            ref_mem[t.addr[7:0]] = t.wdata;
            if (t.dma) exp_ovf = 1'b0;
            e.lat = 3 + S1;
            e.we_low = S1;
        end else begin
            if (t.dma) begin
                exp_dma_rd = v;
                exp_ovf = 1'b0;
            end else begin
                exp_cpu_rd = v;
            end
            e.lat = 3;
            e.we_low = 0;
        end
        e.rdata = t.dma ? exp_dma_rd : exp_cpu_rd;
        e.ovf   = exp_ovf;
        sb.push_back(e);
    endtask

    // Issues one request on bus1 and waits (bounded) for its ack
    task automatic drive_txn(input txn_t t, output int lat, output logic [11:0] rd,
                             output logic ovf, output int we_low, output bit stray);
        bit got;
        @(negedge clk);
        if (t.dma) begin
            bus1.dma_req = 1'b1; bus1.dma_we = t.we; bus1.dma_inc = t.inc;
            bus1.dma_addr = t.addr; bus1.dma_wdata = t.wdata;
        end else begin
            bus1.cpu_req = 1'b1; bus1.cpu_we = t.we;
            bus1.cpu_addr = t.addr; bus1.cpu_wdata = t.wdata;
        end
        lat = 0; we_low = 0; stray = 1'b0; got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!bus1.ram_we_n) we_low++;
            if (t.dma ? bus1.cpu_ack : bus1.dma_ack) stray = 1'b1;
            got = t.dma ? bus1.dma_ack : bus1.cpu_ack;
        end
        rd  = t.dma ? bus1.dma_rdata : bus1.cpu_rdata;
        ovf = bus1.dma_ovf;
        bus1.cpu_req = 1'b0;
        bus1.dma_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        vectors++; if (bus1.ram_ce_n !== 1'b1) begin miscompares++; $display("FAIL reset ce_n: got %b want 1", bus1.ram_ce_n); end
        vectors++; if (bus1.ram_we_n !== 1'b1) begin miscompares++; $display("FAIL reset we_n: got %b want 1", bus1.ram_we_n); end
        vectors++; if (bus1.busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", bus1.busy); end
        vectors++; if ({bus1.cpu_ack, bus1.dma_ack} !== 2'b00) begin miscompares++; $display("FAIL reset acks: got %b want 00", {bus1.cpu_ack, bus1.dma_ack}); end
        vectors++; if (bus1.ram_a !== 15'h0) begin miscompares++; $display("FAIL reset ram_a: got %h want 0000", bus1.ram_a); end
        vectors++; if ({bus1.cpu_rdata, bus1.dma_rdata, bus1.dma_ovf} !== 25'h0) begin miscompares++; $display("FAIL reset rdata/ovf: got %h want 0", {bus1.cpu_rdata, bus1.dma_rdata, bus1.dma_ovf}); end
    endtask

    task automatic test_cpu_rw();
        txn_t t [5];
        exp_t e;
        int lat, wl;
        logic [11:0] rd;
        logic ovf;
        bit stray;
        t[0] = '{1'b0, 1'b1, 1'b0, 15'h0010, 12'o1234};
        t[1] = '{1'b0, 1'b0, 1'b0, 15'h0010, 12'o0000};
        t[2] = '{1'b1, 1'b1, 1'b0, 15'h7F22, 12'o5671};
        t[3] = '{1'b1, 1'b0, 1'b0, 15'h0022, 12'o0000};
        t[4] = '{1'b0, 1'b1, 1'b0, 15'h0011, 12'o7070};
        foreach (t[i]) begin
            push_exp(t[i]);
            drive_txn(t[i], lat, rd, ovf, wl, stray);
            e = sb.pop_front();
            vectors++; if (lat !== e.lat) begin miscompares++; $display("FAIL rw%0d latency: got %0d want %0d", i, lat, e.lat); end
            vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL rw%0d rdata: got %o want %o", i, rd, e.rdata); end
            vectors++; if (wl !== e.we_low) begin miscompares++; $display("FAIL rw%0d we_low cycles: got %0d want %0d", i, wl, e.we_low); end
            vectors++; if (stray !== 1'b0) begin miscompares++; $display("FAIL rw%0d stray ack: got %b want 0", i, stray); end
            if (e.dma) begin
                vectors++; if (ovf !== e.ovf) begin miscompares++; $display("FAIL rw%0d ovf: got %b want %b", i, ovf, e.ovf); end
            end
        end
    endtask

    task automatic test_dma_inc();
        txn_t t [7];
        exp_t e;
        int lat, wl;
        logic [11:0] rd;
        logic ovf;
        bit stray;
        t[0] = '{1'b1, 1'b1, 1'b0, 15'h0030, 12'o7777};
        t[1] = '{1'b1, 1'b0, 1'b1, 15'h0030, 12'o0000};
        t[2] = '{1'b0, 1'b0, 1'b0, 15'h0030, 12'o0000};
        t[3] = '{1'b1, 1'b1, 1'b0, 15'h0031, 12'o0005};
        t[4] = '{1'b1, 1'b1, 1'b1, 15'h0031, 12'o3333};
        t[5] = '{1'b1, 1'b0, 1'b1, 15'h0030, 12'o0000};
        t[6] = '{1'b1, 1'b0, 1'b0, 15'h0031, 12'o0000};
        foreach (t[i]) begin
            push_exp(t[i]);
            drive_txn(t[i], lat, rd, ovf, wl, stray);
            e = sb.pop_front();
            vectors++; if (lat !== e.lat) begin miscompares++; $display("FAIL inc%0d latency: got %0d want %0d", i, lat, e.lat); end
            vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL inc%0d rdata: got %o want %o", i, rd, e.rdata); end
            vectors++; if (wl !== e.we_low) begin miscompares++; $display("FAIL inc%0d we_low cycles: got %0d want %0d", i, wl, e.we_low); end
            vectors++; if (stray !== 1'b0) begin miscompares++; $display("FAIL inc%0d stray ack: got %b want 0", i, stray); end
            if (e.dma) begin
                vectors++; if (ovf !== e.ovf) begin miscompares++; $display("FAIL inc%0d ovf: got %b want %b", i, ovf, e.ovf); end
            end
        end
    endtask

    task automatic test_back_to_back();
        txn_t tc, td;
        exp_t e;
        int lat, wl, n, nc, nd, last_t;
        logic [11:0] rd;
        logic ovf;
        bit stray;
        tc = '{1'b0, 1'b0, 1'b0, 15'h0010, 12'o0000};
        td = '{1'b1, 1'b0, 1'b0, 15'h0031, 12'o0000};
        // A CPU grant first, so the DMA side starts with priority
        push_exp(tc);
        drive_txn(tc, lat, rd, ovf, wl, stray);
        e = sb.pop_front();
        vectors++; if (rd !== e.rdata || lat !== e.lat) begin miscompares++; $display("FAIL arb_pre read: got %o/%0d want %o/%0d", rd, lat, e.rdata, e.lat); end
        push_exp(td); push_exp(tc); push_exp(td); push_exp(tc);
        @(negedge clk);
        bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = tc.addr;
        bus1.dma_req = 1'b1; bus1.dma_we = 1'b0; bus1.dma_inc = 1'b0; bus1.dma_addr = td.addr;
        nc = 0; nd = 0; n = 0;
        while (nc + nd < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (bus1.cpu_ack || bus1.dma_ack) begin
                e = sb.pop_front();
                vectors++; if (bus1.dma_ack !== e.dma || bus1.cpu_ack !== !e.dma) begin miscompares++; $display("FAIL arb grant %0d: got dma=%b cpu=%b want dma=%b", nc + nd, bus1.dma_ack, bus1.cpu_ack, e.dma); end
                rd = bus1.dma_ack ? bus1.dma_rdata : bus1.cpu_rdata;
                vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL arb rdata %0d: got %o want %o", nc + nd, rd, e.rdata); end
                if (bus1.cpu_ack) nc++;
                if (bus1.dma_ack) nd++;
                if (nc == 2) bus1.cpu_req = 1'b0;
                if (nd == 2) bus1.dma_req = 1'b0;
            end
        end
        bus1.cpu_req = 1'b0; bus1.dma_req = 1'b0;
        vectors++; if (nc + nd !== 4) begin miscompares++; $display("FAIL arb completions: got %0d want 4", nc + nd); end
        sb.delete();
        // Lone DMA stream: uninterrupted, one read every 4 cycles
        repeat (3) push_exp(td);
        @(negedge clk);
        bus1.dma_req = 1'b1;
        nd = 0; n = 0; last_t = 0;
        while (nd < 3 && n < 40) begin
            @(negedge clk);
            n++;
            vectors++; if (bus1.cpu_ack !== 1'b0) begin miscompares++; $display("FAIL stream cpu_ack: got %b want 0", bus1.cpu_ack); end
            if (bus1.dma_ack) begin
                e = sb.pop_front();
                vectors++; if (bus1.dma_rdata !== e.rdata) begin miscompares++; $display("FAIL stream rdata: got %o want %o", bus1.dma_rdata, e.rdata); end
                if (nd > 0) begin
                    vectors++; if (n - last_t !== 4) begin miscompares++; $display("FAIL stream spacing: got %0d want 4", n - last_t); end
                end
                last_t = n;
                nd++;
                if (nd == 3) bus1.dma_req = 1'b0;
            end
        end
        bus1.dma_req = 1'b0;
        vectors++; if (nd !== 3) begin miscompares++; $display("FAIL stream completions: got %0d want 3", nd); end
        sb.delete();
    endtask

    task automatic test_reset_mid_write();
        txn_t t [2];
        exp_t e;
        int lat, wl, n;
        logic [11:0] rd;
        logic ovf;
        bit stray, acked;
        @(negedge clk);
        bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b1; bus1.cpu_addr = 15'h0040; bus1.cpu_wdata = 12'o4321;
        n = 0;
        while (bus1.ram_we_n && n < 10) begin
            @(negedge clk);
            n++;
        end
        vectors++; if (bus1.ram_we_n !== 1'b0) begin miscompares++; $display("FAIL midrst reach WR: got we_n=%b want 0", bus1.ram_we_n); end
        reset = 1'b1;
        @(negedge clk);
        vectors++; if ({bus1.ram_we_n, bus1.ram_ce_n} !== 2'b11) begin miscompares++; $display("FAIL midrst strobes: got %b want 11", {bus1.ram_we_n, bus1.ram_ce_n}); end
        vectors++; if (bus1.busy !== 1'b0) begin miscompares++; $display("FAIL midrst busy: got %b want 0", bus1.busy); end
        vectors++; if (bus1.cpu_ack !== 1'b0) begin miscompares++; $display("FAIL midrst ack: got %b want 0", bus1.cpu_ack); end
        reset = 1'b0;
        bus1.cpu_req = 1'b0;
        model_reset();
        acked = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus1.cpu_ack) acked = 1'b1;
        end
        vectors++; if (acked !== 1'b0) begin miscompares++; $display("FAIL midrst late ack: got %b want 0", acked); end
        vectors++; if (bus1.cpu_rdata !== 12'o0) begin miscompares++; $display("FAIL midrst cpu_rdata: got %o want 0", bus1.cpu_rdata); end
        t[0] = '{1'b0, 1'b1, 1'b0, 15'h0041, 12'o1357};
        t[1] = '{1'b0, 1'b0, 1'b0, 15'h0041, 12'o0000};
        foreach (t[i]) begin
            push_exp(t[i]);
            drive_txn(t[i], lat, rd, ovf, wl, stray);
            e = sb.pop_front();
            vectors++; if (lat !== e.lat) begin miscompares++; $display("FAIL post%0d latency: got %0d want %0d", i, lat, e.lat); end
            vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL post%0d rdata: got %o want %o", i, rd, e.rdata); end
        end
    endtask

    task automatic test_strobe3();
        int n, wl, moved;
        logic [14:0] a0;
        logic [11:0] d0;
        bit got;
        @(negedge clk);
        bus3.dma_req = 1'b1; bus3.dma_we = 1'b1; bus3.dma_inc = 1'b0;
        bus3.dma_addr = 15'h0055; bus3.dma_wdata = 12'o2525;
        n = 0; wl = 0; moved = 0; got = 1'b0; a0 = '0; d0 = '0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (!bus3.ram_we_n) wl++;
            if (n == 1) begin
                a0 = bus3.ram_a;
                d0 = bus3.ram_di;
            end else if (n <= 5 && (bus3.ram_a !== a0 || bus3.ram_di !== d0 || bus3.ram_ce_n !== 1'b0)) begin
                moved++;
            end
            got = bus3.dma_ack;
        end
        bus3.dma_req = 1'b0;
        vectors++; if (n !== 6) begin miscompares++; $display("FAIL s3 latency: got %0d want 6", n); end
        vectors++; if (wl !== 3) begin miscompares++; $display("FAIL s3 we_low cycles: got %0d want 3", wl); end
        vectors++; if ({a0, d0} !== {15'h0055, 12'o2525}) begin miscompares++; $display("FAIL s3 setup a/di: got %h/%o want 0055/2525", a0, d0); end
        vectors++; if (moved !== 0) begin miscompares++; $display("FAIL s3 a/di stability: got %0d changes want 0", moved); end
        @(negedge clk);
        bus3.dma_req = 1'b1; bus3.dma_we = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = bus3.dma_ack;
        end
        bus3.dma_req = 1'b0;
        vectors++; if (n !== 3 || bus3.dma_rdata !== 12'o2525) begin miscompares++; $display("FAIL s3 readback: got %o at %0d want 2525 at 3", bus3.dma_rdata, n); end
    endtask

    task automatic test_strobe_glitch();
        vectors++; if (glitch_errs !== 0) begin miscompares++; $display("FAIL strobe glitch: got %0d changes while WE low want 0", glitch_errs); end
    endtask

    initial begin
        bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
        bus1.dma_req = 1'b0; bus1.dma_we = 1'b0; bus1.dma_inc = 1'b0;
        bus1.dma_addr = '0; bus1.dma_wdata = '0;
        bus3.cpu_req = 1'b0; bus3.cpu_we = 1'b0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
        bus3.dma_req = 1'b0; bus3.dma_we = 1'b0; bus3.dma_inc = 1'b0;
        bus3.dma_addr = '0; bus3.dma_wdata = '0;
        test_reset();
        test_cpu_rw();
        test_dma_inc();
        test_back_to_back();
        test_reset_mid_write();
        test_strobe3();
        test_strobe_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
